// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART transmitter among byte requesters
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int GAP_CYCLES     = 2,
  localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             pClk,
  input  logic             pReset,
  input  logic [N_REQ-1:0] req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0] ack,
  output logic             TxStart,
  output logic [7:0]       TxData,
  input  logic             TxDone,
  output logic             busy,
  output logic [IW-1:0]    cur_id,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [19:0]      wdog_q, wdog_d;
  logic [3:0]       gap_q, gap_d;
  logic [IW-1:0]    last_q, last_d;

  logic             tx_start_d;
  logic [7:0]       tx_data_d;
  logic [IW-1:0]    cur_id_d;
  logic [N_REQ-1:0] ack_d;
  logic             timeout_err_d;
  logic             busy_d;

  logic             grant_hit;
  logic [IW-1:0]    grant_idx;
  logic             wdog_expire;
  logic             gap_last;

  // Search starts one past the last served requester and wraps, giving rotation.
  always_comb begin
    int cand;
    cand      = 0;
    grant_hit = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_q) + k) % N_REQ;
      if (!grant_hit && req[cand]) begin
        grant_hit = 1'b1;
        grant_idx = IW'(cand);
      end
    end
  end

  assign wdog_expire = (wdog_q == 20'(TIMEOUT_CYCLES - 1));
  assign gap_last    = (gap_q == 4'(GAP_CYCLES - 1));

  always_ff @(posedge pClk) begin
    if (!pReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_hit) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   if (TxDone || wdog_expire) state_d = S_GAP;
      S_GAP:    if (gap_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values for every registered output and internal counter.
  always_comb begin
    tx_start_d    = 1'b0;
    tx_data_d     = TxData;
    cur_id_d      = cur_id;
    ack_d         = '0;
    timeout_err_d = 1'b0;
    last_d        = last_q;
    wdog_d        = wdog_q;
    gap_d         = gap_q;
    busy_d        = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (grant_hit) begin
          tx_data_d  = req_data[{grant_idx, 3'b000} +: 8];
          cur_id_d   = grant_idx;
          tx_start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        wdog_d = '0;
      end
      S_WAIT: begin
        // TxDone takes precedence over a watchdog expiring on the same cycle.
        if (TxDone) begin
          ack_d[cur_id] = 1'b1;
          last_d        = cur_id;
          gap_d         = '0;
        end else if (wdog_expire) begin
          timeout_err_d = 1'b1;
          last_d        = cur_id;
          gap_d         = '0;
        end else begin
          wdog_d = wdog_q + 20'd1;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (!pReset) begin
      last_q      <= IW'(N_REQ - 1);
      wdog_q      <= '0;
      gap_q       <= '0;
      TxStart     <= 1'b0;
      TxData      <= 8'h00;
      cur_id      <= '0;
      ack         <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      last_q      <= last_d;
      wdog_q      <= wdog_d;
      gap_q       <= gap_d;
      TxStart     <= tx_start_d;
      TxData      <= tx_data_d;
      cur_id      <= cur_id_d;
      ack         <= ack_d;
      timeout_err <= timeout_err_d;
      busy        <= busy_d;
    end
  end

endmodule
